// File: rtl/pc_redirect_unit.sv
// Fetch-PC owner for the pipelined core: applies EX-stage branch/JAL/JALR redirects,
// squashes the front end, traps on misaligned targets and counts accepted redirects.
module pc_redirect_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(32'h0000_0000),
  parameter int              CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             branch_taken,
  input  logic             jal,
  input  logic             jalr,
  input  logic [XLEN-1:0]  ex_pc,
  input  logic [XLEN-1:0]  ex_imm,
  input  logic [XLEN-1:0]  ex_rs1,
  output logic [XLEN-1:0]  pc,
  output logic [XLEN-1:0]  pc_plus4,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic             trap,
  output logic [XLEN-1:0]  trap_pc,
  output logic [CNT_W-1:0] redirect_cnt
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_SHADOW = 2'd1,
    ST_TRAP   = 2'd2
  } state_t;

  localparam logic [XLEN-1:0]  PC_STEP  = XLEN'(32'd4);
  localparam logic [XLEN-1:0]  BIT0_CLR = ~(XLEN'(32'd1));
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);

  state_t           r_state;
  state_t           w_state_next;
  logic [XLEN-1:0]  r_pc;
  logic [XLEN-1:0]  r_trap_pc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_trap;

  logic [XLEN-1:0]  w_seq_pc;
  logic [XLEN-1:0]  w_br_target;
  logic [XLEN-1:0]  w_jalr_sum;
  logic [XLEN-1:0]  w_target;
  logic [XLEN-1:0]  w_pc_next;
  logic             w_req;
  logic             w_misaligned;
  logic             w_flush;
  logic             w_accept;
  logic             w_trap_set;

  assign w_seq_pc    = r_pc + PC_STEP;
  assign w_br_target = ex_pc + ex_imm;
  assign w_jalr_sum  = ex_rs1 + ex_imm;
  assign w_req       = branch_taken | jal | jalr;

  // Redirect target selection; JALR has priority and drops bit 0.
  always_comb begin
    w_target = w_br_target;
    if (jalr) begin
      w_target = w_jalr_sum & BIT0_CLR;
    end else begin
      w_target = w_br_target;
    end
  end

  assign w_misaligned = w_target[1];

  // Next-state, next-PC and flush decode.
  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_flush      = 1'b0;
    w_accept     = 1'b0;
    w_trap_set   = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (w_req) begin
          w_flush = 1'b1;
          if (w_misaligned) begin
            w_trap_set   = 1'b1;
            w_state_next = ST_TRAP;
          end else begin
            w_accept     = 1'b1;
            w_pc_next    = w_target;
            w_state_next = ST_SHADOW;
          end
        end else if (stall) begin
          w_pc_next = r_pc;
        end else begin
          w_pc_next = w_seq_pc;
        end
      end
      ST_SHADOW: begin
        // EX holds the bubble created by our own flush, so requests are ignored here.
        if (stall) begin
          w_pc_next = r_pc;
        end else begin
          w_pc_next = w_seq_pc;
        end
        w_state_next = ST_RUN;
      end
      ST_TRAP: begin
        w_flush      = 1'b1;
        w_state_next = ST_TRAP;
      end
      default: begin
        w_state_next = ST_RUN;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Fetch PC register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc <= RESET_PC;
    end else begin
      r_pc <= w_pc_next;
    end
  end

  // Sticky trap flag and faulting instruction PC.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_trap    <= 1'b0;
      r_trap_pc <= XLEN'(32'h0000_0000);
    end else if (w_trap_set) begin
      r_trap    <= 1'b1;
      r_trap_pc <= ex_pc;
    end else begin
      r_trap    <= r_trap;
      r_trap_pc <= r_trap_pc;
    end
  end

  // Saturating count of accepted redirects.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= CNT_W'(32'd0);
    end else if (w_accept && (r_cnt != CNT_MAX)) begin
      r_cnt <= r_cnt + CNT_ONE;
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign pc           = r_pc;
  assign pc_plus4     = w_seq_pc;
  assign flush_if_id  = w_flush & rst;
  assign flush_id_ex  = w_flush & rst;
  assign trap         = r_trap;
  assign trap_pc      = r_trap_pc;
  assign redirect_cnt = r_cnt;

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Bench for pc_redirect_unit: directed vector table, hand sequences and random stimulus
// against a behavioural model; a second instance uses a 2-bit counter for saturation.
module tb_pc_redirect_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, stall, bt, jal, jalr;
  logic [31:0] ex_pc, ex_imm, ex_rs1;
  logic [31:0] pc, pc_plus4, trap_pc;
  logic        fl_ifid, fl_idex, trap;
  logic [15:0] cnt;
  logic [31:0] pc_b, pc_plus4_b, trap_pc_b;
  logic        fl_ifid_b, fl_idex_b, trap_b;
  logic [1:0]  cnt_b;

  pc_redirect_unit #(.XLEN(32), .RESET_PC(32'h0000_0000), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .stall(stall), .branch_taken(bt), .jal(jal), .jalr(jalr),
    .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_rs1(ex_rs1), .pc(pc), .pc_plus4(pc_plus4),
    .flush_if_id(fl_ifid), .flush_id_ex(fl_idex), .trap(trap), .trap_pc(trap_pc),
    .redirect_cnt(cnt));

  pc_redirect_unit #(.XLEN(32), .RESET_PC(32'h0000_0000), .CNT_W(2)) u_dut_small (
    .clk(clk), .rst(rst), .stall(stall), .branch_taken(bt), .jal(jal), .jalr(jalr),
    .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_rs1(ex_rs1), .pc(pc_b), .pc_plus4(pc_plus4_b),
    .flush_if_id(fl_ifid_b), .flush_id_ex(fl_idex_b), .trap(trap_b), .trap_pc(trap_pc_b),
    .redirect_cnt(cnt_b));

  int checks = 0;
  int errors = 0;

  // Behavioural model: architectural PC, "just redirected" and "trapped" flags.
  logic [31:0] m_pc, m_tpc;
  bit          m_shadow, m_trap;
  int          m_cnt;

  typedef struct {
    logic        bt, jal, jalr, st;
    logic [31:0] epc, imm, rs1;
    logic [31:0] e_pc;
    logic        e_fl;
    logic [31:0] e_cnt;
    logic        e_trap;
    logic [31:0] e_tpc;
  } vec_t;

  vec_t tbl[15];

  function automatic vec_t mk(logic b, logic j, logic jr, logic st, logic [31:0] epc,
                              logic [31:0] imm, logic [31:0] rs1, logic [31:0] e_pc,
                              logic e_fl, logic [31:0] e_cnt, logic e_trap, logic [31:0] e_tpc);
    vec_t v;
    v.bt = b; v.jal = j; v.jalr = jr; v.st = st; v.epc = epc; v.imm = imm; v.rs1 = rs1;
    v.e_pc = e_pc; v.e_fl = e_fl; v.e_cnt = e_cnt; v.e_trap = e_trap; v.e_tpc = e_tpc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic m_req();
    return bt | jal | jalr;
  endfunction

  function automatic logic [31:0] m_target();
    logic [31:0] s;
    if (jalr) begin
      s = ex_rs1 + ex_imm;
      return s - (s % 32'd2);
    end
    return ex_pc + ex_imm;
  endfunction

  task automatic set_in(input logic b, input logic j, input logic jr, input logic st,
                        input logic [31:0] epc, input logic [31:0] imm, input logic [31:0] rs1);
    bt = b; jal = j; jalr = jr; stall = st; ex_pc = epc; ex_imm = imm; ex_rs1 = rs1;
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_tpc = 32'h0; m_shadow = 1'b0; m_trap = 1'b0; m_cnt = 0;
  endtask

  task automatic check_model();
    logic exp_fl;
    exp_fl = m_trap || (!m_shadow && m_req());
    chk("pc", pc, m_pc);
    chk("pc_plus4", pc_plus4, m_pc + 32'd4);
    chk("flush_if_id", 32'(fl_ifid), 32'(exp_fl));
    chk("flush_id_ex", 32'(fl_idex), 32'(exp_fl));
    chk("trap", 32'(trap), 32'(m_trap));
    chk("trap_pc", trap_pc, m_tpc);
    chk("redirect_cnt", 32'(cnt), (m_cnt > 65535) ? 32'd65535 : 32'(m_cnt));
    chk("redirect_cnt_w2", 32'(cnt_b), (m_cnt > 3) ? 32'd3 : 32'(m_cnt));
    chk("pc_w2", pc_b, m_pc);
  endtask

  task automatic step_model();
    logic [31:0] t;
    if (m_trap) begin
      m_trap = 1'b1;
    end else if (m_shadow) begin
      m_shadow = 1'b0;
      if (!stall) m_pc = m_pc + 32'd4;
    end else if (m_req()) begin
      t = m_target();
      if ((t % 32'd4) >= 32'd2) begin
        m_trap = 1'b1;
        m_tpc  = ex_pc;
      end else begin
        m_pc = t;
        m_cnt++;
        m_shadow = 1'b1;
      end
    end else if (!stall) begin
      m_pc = m_pc + 32'd4;
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    check_model();
    @(posedge clk);
    step_model();
    #1;
  endtask

  // Asynchronous reset pulse; outputs must take reset values before any clock edge.
  task automatic do_reset(input logic req_during);
    set_in(1'b0, req_during, 1'b0, 1'b1, 32'h40, 32'h10, 32'h0);
    rst = 1'b0;
    #2;
    model_reset();
    chk("rst_pc", pc, 32'h0);
    chk("rst_trap", 32'(trap), 32'h0);
    chk("rst_trap_pc", trap_pc, 32'h0);
    chk("rst_cnt", 32'(cnt), 32'h0);
    chk("rst_flush", 32'(fl_ifid | fl_idex), 32'h0);
    @(posedge clk);
    #1;
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    rst = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] sat_exp[5];
    sat_exp[0] = 32'd1; sat_exp[1] = 32'd2; sat_exp[2] = 32'd3;
    sat_exp[3] = 32'd3; sat_exp[4] = 32'd3;

    tbl[0]  = mk(0,0,0,0, 32'h0,    32'h0,  32'h0,   32'h0,   0, 0, 0, 32'h0);
    tbl[1]  = mk(0,0,0,0, 32'h0,    32'h0,  32'h0,   32'h4,   0, 0, 0, 32'h0);
    tbl[2]  = mk(0,0,0,0, 32'h0,    32'h0,  32'h0,   32'h8,   0, 0, 0, 32'h0);
    tbl[3]  = mk(0,0,0,0, 32'h0,    32'h0,  32'h0,   32'hC,   0, 0, 0, 32'h0);
    tbl[4]  = mk(1,0,0,0, 32'h8,    32'h20, 32'h0,   32'h10,  1, 0, 0, 32'h0);
    tbl[5]  = mk(1,0,0,0, 32'h8,    32'h20, 32'h0,   32'h28,  0, 1, 0, 32'h0);
    tbl[6]  = mk(0,1,1,1, 32'h1000, 32'h4,  32'h101, 32'h2C,  1, 1, 0, 32'h0);
    tbl[7]  = mk(0,0,0,0, 32'h0,    32'h0,  32'h0,   32'h104, 0, 2, 0, 32'h0);
    tbl[8]  = mk(0,0,0,1, 32'h0,    32'h0,  32'h0,   32'h108, 0, 2, 0, 32'h0);
    tbl[9]  = mk(0,1,0,0, 32'h40,   32'h2,  32'h0,   32'h108, 1, 2, 0, 32'h0);
    for (int i = 10; i < 15; i++)
      tbl[i] = mk(1,0,0,0, 32'h0, 32'h100, 32'h0, 32'h108, 1, 2, 1, 32'h40);

    rst = 1'b1;
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    #1;
    do_reset(1'b1);

    for (int i = 0; i < 15; i++) begin
      set_in(tbl[i].bt, tbl[i].jal, tbl[i].jalr, tbl[i].st, tbl[i].epc, tbl[i].imm, tbl[i].rs1);
      @(negedge clk);
      check_model();
      chk($sformatf("vec%0d_pc", i), pc, tbl[i].e_pc);
      chk($sformatf("vec%0d_flush", i), 32'(fl_ifid & fl_idex), 32'(tbl[i].e_fl));
      chk($sformatf("vec%0d_cnt", i), 32'(cnt), tbl[i].e_cnt);
      chk($sformatf("vec%0d_trap", i), 32'(trap), 32'(tbl[i].e_trap));
      chk($sformatf("vec%0d_trap_pc", i), trap_pc, tbl[i].e_tpc);
      @(posedge clk);
      step_model();
      #1;
    end
    do_reset(1'b1);

    // Five aligned redirects, each followed by its shadow cycle.
    for (int k = 0; k < 5; k++) begin
      set_in(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'(32'h100 * (k + 1)), 32'h0);
      cycle();
      chk($sformatf("sat%0d_cnt_w2", k), 32'(cnt_b), sat_exp[k]);
      chk($sformatf("sat%0d_cnt", k), 32'(cnt), 32'(k + 1));
      set_in(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
      cycle();
    end

    // PC wrap at the top of the address space.
    set_in(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'hFFFF_FFF8, 32'h0);
    cycle();
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    cycle();
    chk("pc_at_top", pc, 32'hFFFF_FFFC);
    chk("pc_plus4_wrap", pc_plus4, 32'h0);
    cycle();
    chk("pc_wrap", pc, 32'h0);

    // Asynchronous reset in the middle of a shadow cycle.
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 32'h100, 32'h100, 32'h0);
    cycle();
    chk("shadow_pc", pc, 32'h200);
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    @(negedge clk);
    #1;
    do_reset(1'b1);

    // Random stimulus against the model.
    for (int n = 0; n < 1500; n++) begin
      if ((m_trap && ($urandom % 8 == 0)) || ($urandom % 250 == 0)) begin
        do_reset(1'($urandom % 2));
      end else begin
        bt     = ($urandom % 4) == 0;
        jal    = ($urandom % 6) == 0;
        jalr   = ($urandom % 6) == 0;
        stall  = ($urandom % 3) == 0;
        ex_pc  = $urandom & 32'hFFFF_FFFC;
        ex_imm = (($urandom % 16) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
        ex_rs1 = (($urandom % 16) == 0) ? $urandom
                                          : (($urandom & 32'hFFFF_FFFC) | 32'($urandom % 2));
        cycle();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
